// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size codes, op-field indices and FSM states for the M-stage memory controller
package mips_mem_pkg;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam int OP_UNS = 2;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-lane strobes/replication and load lane extraction with sign/zero extension
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic        st_wr,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);
  logic [15:0] lane;
  always_comb begin
    lane = 16'(rdata >> {ld_lo, 3'b000});
    wstrb = !st_wr ? 4'b0000 :
            st_size == MEM_B ? 4'b0001 << st_lo :
            st_size == MEM_H ? 4'b0011 << {st_lo[1], 1'b0} : 4'b1111;
    wdata = st_size == MEM_B ? {4{st_data[7:0]}} :
            st_size == MEM_H ? {2{st_data[15:0]}} : st_data;
    ld_data = ld_size == MEM_B ? {{24{lane[7] & ~ld_uns}}, lane[7:0]} :
              ld_size == MEM_H ? {{16{lane[15] & ~ld_uns}}, lane} : rdata;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage load/store controller running a multi-cycle bus access with stall, flush and timeout
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  mem_op_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] wdata_M,
  input  logic        flush_M,
  input  logic        advance,
  output logic        stall_M,
  output logic [31:0] result_M,
  output logic        addr_err_M,
  output logic        bus_err_M,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] size;
  logic start, tmo, uns_q;
  logic [3:0] wstrb_n;
  logic [31:0] wdata_n, ld_data;
  assign size = mem_op_M[1:0];
  assign addr_err_M = mem_en_M & ((size == MEM_H & alu_out_M[0]) | (size == MEM_W & |alu_out_M[1:0]));
  assign start = state == IDLE & mem_en_M & ~addr_err_M & ~flush_M;
  assign stall_M = start | state == REQ | state == WAIT | state == DRAIN;
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
  assign data_req = state == REQ;
  mem_lane_align u_align (
    .st_wr   (mem_wr_M),
    .st_size (size),
    .st_lo   (alu_out_M[1:0]),
    .st_data (wdata_M),
    .ld_size (data_size),
    .ld_uns  (uns_q),
    .ld_lo   (data_addr[1:0]),
    .rdata   (data_rdata),
    .wstrb   (wstrb_n),
    .wdata   (wdata_n),
    .ld_data (ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      uns_q <= 1'b0;
      data_wr <= 1'b0;
      data_size <= 2'd0;
      data_addr <= '0;
      data_wstrb <= '0;
      data_wdata <= '0;
      result_M <= '0;
      bus_err_M <= 1'b0;
    end else begin
      cnt <= '0;
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          uns_q <= mem_op_M[OP_UNS];
          data_wr <= mem_wr_M;
          data_size <= size;
          data_addr <= alu_out_M;
          data_wstrb <= wstrb_n;
          data_wdata <= wdata_n;
        end
        REQ: if (flush_M) begin
          state <= data_addr_ok & ~data_data_ok ? DRAIN : IDLE;
        end else if (data_addr_ok & data_data_ok) begin
          state <= DONE;
          result_M <= data_wr ? '0 : ld_data;
          bus_err_M <= 1'b0;
        end else if (tmo) begin
          state <= DONE;
          result_M <= '0;
          bus_err_M <= 1'b1;
        end else begin
          state <= data_addr_ok ? WAIT : REQ;
          cnt <= cnt + 1'b1;
        end
        WAIT: if (flush_M) begin
          state <= data_data_ok ? IDLE : DRAIN;
        end else if (data_data_ok) begin
          state <= DONE;
          result_M <= data_wr ? '0 : ld_data;
          bus_err_M <= 1'b0;
        end else if (tmo) begin
          state <= DONE;
          result_M <= '0;
          bus_err_M <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DRAIN: if (data_data_ok) state <= IDLE;
        DONE: if (advance) begin
          state <= IDLE;
          result_M <= '0;
          bus_err_M <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a scripted SRAM-like bus responder
module tb_mem_access_ctrl;
  logic clk, rst, mem_en_M, mem_wr_M, flush_M, advance;
  logic [2:0] mem_op_M;
  logic [31:0] alu_out_M, wdata_M, data_rdata;
  logic stall_M, addr_err_M, bus_err_M, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [31:0] result_M, data_addr, data_wdata;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [31:0] res;
    logic err;
    logic [3:0] strb;
    logic [31:0] wd;
    logic [1:0] sz;
    logic wr;
    int stall;
  } exp_t;
  exp_t sb[$];
  mem_access_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .mem_en_M(mem_en_M), .mem_wr_M(mem_wr_M), .mem_op_M(mem_op_M),
    .alu_out_M(alu_out_M), .wdata_M(wdata_M), .flush_M(flush_M), .advance(advance),
    .stall_M(stall_M), .result_M(result_M), .addr_err_M(addr_err_M), .bus_err_M(bus_err_M),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic access(input logic wr, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int aok, input int dok, input logic [31:0] res,
                        input logic err, input logic [3:0] strb, input logic [31:0] ewd, input int stall, input int hold);
    int n, acc, reqs, stalls;
    logic cap;
    logic [3:0] c_strb;
    logic [31:0] c_wd, c_addr;
    logic [1:0] c_sz;
    logic c_wr;
    exp_t e;
    @(negedge clk);
    mem_en_M = 1; mem_wr_M = wr; mem_op_M = op; alu_out_M = addr; wdata_M = wd; data_rdata = rd;
    sb.push_back('{res, err, strb, ewd, op[1:0], wr, stall});
    #1;
    n = 0; acc = -1; reqs = 0; stalls = 0; cap = 0;
    c_strb = '0; c_wd = '0; c_addr = '0; c_sz = '0; c_wr = 0;
    while (n < 40 && stall_M) begin
      stalls++;
      if (data_req && !cap) begin
        cap = 1; c_strb = data_wstrb; c_wd = data_wdata; c_addr = data_addr; c_sz = data_size; c_wr = data_wr;
      end
      data_addr_ok = 0;
      if (data_req && acc < 0) begin
        if (reqs == aok) begin data_addr_ok = 1; acc = n; end
        reqs++;
      end
      data_data_ok = acc >= 0 && n - acc == dok;
      @(negedge clk); #1;
      n++;
    end
    data_addr_ok = 0; data_data_ok = 0; mem_en_M = 0;
    if (stall_M) chk("access_completes", 32'(stall_M), 32'd0);
    e = sb.pop_front();
    chk("result", result_M, e.res);
    chk("bus_err", 32'(bus_err_M), 32'(e.err));
    chk("stall_cycles", 32'(stalls), 32'(e.stall));
    chk("req_addr", c_addr, addr);
    chk("req_wstrb", 32'(c_strb), 32'(e.strb));
    chk("req_size", 32'(c_sz), 32'(e.sz));
    chk("req_wr", 32'(c_wr), 32'(e.wr));
    if (e.wr) chk("req_wdata", c_wd, e.wd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("hold_result", result_M, e.res);
      chk("hold_bus_err", 32'(bus_err_M), 32'(e.err));
    end
    advance = 1;
    @(negedge clk);
    advance = 0;
    #1;
    chk("adv_result_clr", result_M, 32'd0);
    chk("adv_bus_err_clr", 32'(bus_err_M), 32'd0);
    chk("adv_stall", 32'(stall_M), 32'd0);
  endtask
  initial begin
    logic seen;
    rst = 1; mem_en_M = 0; mem_wr_M = 0; mem_op_M = 0; alu_out_M = 0; wdata_M = 0; flush_M = 0;
    advance = 0; data_rdata = 0; data_addr_ok = 0; data_data_ok = 1;
    repeat (3) @(negedge clk);
    rst = 0; data_data_ok = 0;
    #1;
    chk("rst_stall", 32'(stall_M), 0);
    chk("rst_req", 32'(data_req), 0);
    chk("rst_result", result_M, 0);
    chk("rst_bus_err", 32'(bus_err_M), 0);
    chk("rst_wstrb", 32'(data_wstrb), 0);
    chk("rst_addr", data_addr, 0);
    access(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 0, 4'b0000, 0, 4, 2);
    access(0, 3'b000, 32'h103, 0, 32'h80112233, 1, 0, 32'hFFFFFF80, 0, 4'b0000, 0, 3, 0);
    access(0, 3'b100, 32'h103, 0, 32'h80112233, 0, 0, 32'h00000080, 0, 4'b0000, 0, 2, 0);
    access(0, 3'b001, 32'h102, 0, 32'h80112233, 0, 1, 32'hFFFF8011, 0, 4'b0000, 0, 3, 0);
    access(0, 3'b101, 32'h100, 0, 32'h1234F00D, 0, 0, 32'h0000F00D, 0, 4'b0000, 0, 2, 0);
    access(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h55555555, 0, 1, 0, 0, 4'b1100, 32'hABCDABCD, 3, 0);
    access(1, 3'b000, 32'h101, 32'h12345677, 0, 0, 0, 0, 0, 4'b0010, 32'h77777777, 2, 0);
    access(1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 2, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 5, 0);
    access(0, 3'b010, 32'h108, 0, 32'h11111111, 99, 0, 0, 1, 4'b0000, 0, 9, 5);
    @(negedge clk);
    mem_en_M = 1; mem_wr_M = 0; mem_op_M = 3'b010; alu_out_M = 32'h101;
    #1;
    chk("misalign_err", 32'(addr_err_M), 1);
    chk("misalign_stall", 32'(stall_M), 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      seen = seen | data_req | stall_M;
    end
    chk("misalign_no_req", 32'(seen), 0);
    mem_op_M = 3'b001; alu_out_M = 32'h103; #1;
    chk("misalign_h_err", 32'(addr_err_M), 1);
    mem_op_M = 3'b000; #1;
    chk("byte_no_err", 32'(addr_err_M), 0);
    mem_en_M = 0;
    @(negedge clk);
    mem_en_M = 1; mem_op_M = 3'b010; alu_out_M = 32'h200; data_rdata = 32'h12345678;
    sb.push_back('{32'h0, 1'b0, 4'h0, 32'h0, 2'd2, 1'b0, 0});
    @(negedge clk); #1;
    chk("fl_req", 32'(data_req), 1);
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0; flush_M = 1;
    #1;
    chk("fl_wait_stall", 32'(stall_M), 1);
    @(negedge clk);
    flush_M = 0; mem_en_M = 0;
    #1;
    chk("drain_stall", 32'(stall_M), 1);
    chk("drain_no_req", 32'(data_req), 0);
    @(negedge clk);
    @(negedge clk);
    data_data_ok = 1;
    #1;
    chk("drain_stall_late", 32'(stall_M), 1);
    @(negedge clk);
    data_data_ok = 0;
    #1;
    begin
      exp_t e;
      e = sb.pop_front();
      chk("drain_result", result_M, e.res);
      chk("drain_bus_err", 32'(bus_err_M), 32'(e.err));
    end
    chk("drain_idle_stall", 32'(stall_M), 0);
    @(negedge clk);
    mem_en_M = 1; mem_wr_M = 1; mem_op_M = 3'b010; alu_out_M = 32'h300; wdata_M = 32'h0BADF00D;
    @(negedge clk);
    data_addr_ok = 1; flush_M = 1;
    @(negedge clk);
    data_addr_ok = 0; flush_M = 0; mem_en_M = 0;
    #1;
    chk("req_flush_drain", 32'(stall_M), 1);
    data_data_ok = 1;
    @(negedge clk);
    data_data_ok = 0;
    #1;
    chk("req_flush_idle", 32'(stall_M), 0);
    chk("req_flush_result", result_M, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
